// File: rtl/sram_pack_writer_pkg.sv
// Shared definitions for the 160x32 SRAM pack/unpack path.
// Both the write-side packer and the read-side unpacker import this package,
// so the word layout (LO_LSB / HI_LSB) and frame geometry stay in lock-step.
package sram_pack_writer_pkg;

  localparam int unsigned DW        = 9;    // sample width
  localparam int unsigned WW        = 32;   // SRAM word width
  localparam int unsigned AW        = 8;    // SRAM address width
  localparam int unsigned DEPTH     = 160;  // words per frame, must be <= 2**AW - 1
  localparam int unsigned BASE_ADDR = 0;    // first word address of a frame

  // Field positions inside a packed word: first sample low, second above it.
  localparam int unsigned LO_LSB = 0;
  localparam int unsigned HI_LSB = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FULL  = 3'd4
  } spw_state_e;

endpackage

// File: rtl/sram_pack_writer.sv
// sram_pack_writer: packs pairs of 9-bit samples into 32-bit words and writes
// them to the single-port SRAM wrapper at incrementing addresses.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   start          arm a new frame (IDLE or FULL only)
//   in_valid       sample valid
//   in_data        sample value
//   in_ready       sample accepted this cycle when in_valid is also high
//   flush          close the frame, writing any half-filled word
//   mem_ry         SRAM ready; a write only happens while high
//   we_n           SRAM write enable, active-low
//   w_addr         SRAM write address
//   write_data     packed word
//   words_written  words written in the current frame
//   busy           high outside IDLE and FULL
//   full           DEPTH words written, frame closed
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no frame armed, waiting for start
// LOW    | waiting for the first sample of a word
// HIGH   | first sample held, waiting for the second (or a flush)
// WRITE  | word complete, waiting for mem_ry to issue the write
// FULL   | DEPTH words written, frame closed until the next start
module sram_pack_writer
  import sram_pack_writer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [DW-1:0]             in_data,
  output logic                      in_ready,
  input  logic                      flush,
  input  logic                      mem_ry,
  output logic                      we_n,
  output logic [AW-1:0]             w_addr,
  output logic [WW-1:0]             write_data,
  output logic [AW-1:0]             words_written,
  output logic                      busy,
  output logic                      full
);

  localparam logic [AW-1:0] BASE_A  = AW'(BASE_ADDR);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  spw_state_e     state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [WW-1:0]  data_q, data_d;
  logic [AW-1:0]  words_q, words_d;
  logic           pend_q, pend_d;

  logic           ready;
  logic           xfer;
  logic [AW-1:0]  words_inc;

  // in_ready is a pure state decode so it never loops back through in_valid.
  assign ready     = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign xfer      = in_valid && ready;
  assign words_inc = words_q + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_A;
      data_q  <= '0;
      words_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      words_q <= words_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    pend_d  = pend_q;

    unique case (state_q)
      ST_IDLE, ST_FULL: begin
        if (start) begin
          state_d = ST_LOW;
          addr_d  = BASE_A;
          words_d = '0;
          data_d  = '0;
          pend_d  = 1'b0;
        end
      end

      ST_LOW: begin
        if (xfer) begin
          // Clearing the whole word keeps the upper bits zero after a previous write.
          data_d                 = '0;
          data_d[LO_LSB +: DW]   = in_data;
          state_d                = ST_HIGH;
          if (flush) pend_d = 1'b1;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end

      ST_HIGH: begin
        if (xfer) begin
          data_d[HI_LSB +: DW] = in_data;
          pend_d               = pend_q | flush;
          state_d              = ST_WRITE;
        end else if (flush && !pend_q) begin
          // Flush a half word: upper sample slot written as zero.
          data_d[HI_LSB +: DW] = '0;
          pend_d               = 1'b1;
          state_d              = ST_WRITE;
        end
        // A flush taken together with the first sample waits here for the
        // second one; repeating flush meanwhile changes nothing.
      end

      ST_WRITE: begin
        if (mem_ry) begin
          words_d = words_inc;
          if (words_inc == DEPTH_A) begin
            addr_d  = BASE_A;
            pend_d  = 1'b0;
            state_d = ST_FULL;
          end else begin
            addr_d = addr_q + AW'(1);
            if (pend_q) begin
              pend_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_LOW;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready      = ready;
  assign we_n          = !((state_q == ST_WRITE) && mem_ry);
  assign w_addr        = addr_q;
  assign write_data    = data_q;
  assign words_written = words_q;
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_FULL);
  assign full          = (state_q == ST_FULL);

endmodule

// File: tb/tb_sram_pack_writer.sv
module tb_sram_pack_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [8:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        mem_ry;
  logic        we_n;
  logic [7:0]  w_addr;
  logic [31:0] write_data;
  logic [7:0]  words_written;
  logic        busy;
  logic        full;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries: {addr[7:0], data[31:0]}
  logic [39:0] sb_q[$];
  int          n_writes_seen = 0;
  int          n_writes_exp  = 0;

  // Reference model of the write pointer
  logic [7:0]  m_addr;
  int          m_words;

  sram_pack_writer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .flush         (flush),
    .mem_ry        (mem_ry),
    .we_n          (we_n),
    .w_addr        (w_addr),
    .write_data    (write_data),
    .words_written (words_written),
    .busy          (busy),
    .full          (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [8:0] lo, input logic [8:0] hi);
    return {14'b0, hi, lo};
  endfunction

  task automatic push_write(input logic [31:0] d);
    sb_q.push_back({m_addr, d});
    n_writes_exp++;
    m_words++;
    if (m_words == 160) m_addr = 8'd0;
    else                m_addr = m_addr + 8'd1;
  endtask

  task automatic model_arm();
    m_addr  = 8'd0;
    m_words = 0;
  endtask

  // Write monitor: every we_n pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (we_n === 1'b0) begin
      logic [39:0] e;
      n_writes_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_write", {24'b0, w_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", {24'b0, w_addr}, {24'b0, e[39:32]});
        check("wr_data", write_data, e[31:0]);
        check("wr_in_ready", {31'b0, in_ready}, 32'd0);
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic send(input logic [8:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_arm();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    logic [8:0] lo;
    logic [8:0] d;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    flush = 1'b0; mem_ry = 1'b1;
    model_arm();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_we_n",     {31'b0, we_n},     32'd1);
    check("rst_w_addr",   {24'b0, w_addr},   32'd0);
    check("rst_data",     write_data,        32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_words",    {24'b0, words_written}, 32'd0);
    check("rst_busy",     {31'b0, busy},     32'd0);
    check("rst_full",     {31'b0, full},     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // One word
    pulse_start();
    check("armed_busy", {31'b0, busy}, 32'd1);
    send(9'h1A5);
    push_write(pack(9'h1A5, 9'h0F3));
    send(9'h0F3);
    @(negedge clk);
    check("one_words", {24'b0, words_written}, 32'd1);
    check("one_in_ready", {31'b0, in_ready}, 32'd1);
    pulse_flush();
    check("flush_low_busy", {31'b0, busy}, 32'd0);
    check("flush_low_words", {24'b0, words_written}, 32'd1);

    // Full frame, back to back
    pulse_start();
    for (int i = 0; i < 320; i++) begin
      d = 9'($urandom_range(0, 511));
      if (i % 2 == 0) lo = d;
      else            push_write(pack(lo, d));
      send(d);
    end
    @(negedge clk);
    check("full_full",     {31'b0, full},     32'd1);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_busy",     {31'b0, busy},     32'd0);
    check("full_words",    {24'b0, words_written}, 32'd160);
    check("full_w_addr",   {24'b0, w_addr},   32'd0);
    in_valid = 1'b1; in_data = 9'h1FF; flush = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("full_hold",     {31'b0, full},     32'd1);
    check("full_hold_wds", {24'b0, words_written}, 32'd160);
    pulse_start();
    check("rearm_full",  {31'b0, full},     32'd0);
    check("rearm_ready", {31'b0, in_ready}, 32'd1);
    check("rearm_addr",  {24'b0, w_addr},   32'd0);
    check("rearm_words", {24'b0, words_written}, 32'd0);

    // Half word flushed from HIGH
    send(9'h055);
    push_write(32'h0000_0055);
    pulse_flush();
    @(negedge clk);
    check("hflush_busy",  {31'b0, busy}, 32'd0);
    check("hflush_words", {24'b0, words_written}, 32'd1);

    // Stall in WRITE
    pulse_start();
    mem_ry = 1'b0;
    send(9'h0AA);
    push_write(pack(9'h0AA, 9'h133));
    send(9'h133);
    for (int i = 0; i < 5; i++) begin
      check("stall_we_n",  {31'b0, we_n},     32'd1);
      check("stall_data",  write_data,        pack(9'h0AA, 9'h133));
      check("stall_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    mem_ry = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_after_we_n", {31'b0, we_n}, 32'd1);
    check("stall_words", {24'b0, words_written}, 32'd1);

    // Flush together with the first sample
    in_valid = 1'b1; in_data = 9'h0C3; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("fl1_wait_ready", {31'b0, in_ready}, 32'd1);
    check("fl1_wait_we_n",  {31'b0, we_n},     32'd1);
    pulse_flush();
    check("fl1_idem_ready", {31'b0, in_ready}, 32'd1);
    check("fl1_idem_busy",  {31'b0, busy},     32'd1);
    push_write(pack(9'h0C3, 9'h1E1));
    send(9'h1E1);
    @(negedge clk);
    check("fl1_busy",  {31'b0, busy}, 32'd0);
    check("fl1_words", {24'b0, words_written}, 32'd2);

    // Reset in HIGH drops the half word
    pulse_start();
    send(9'h17F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rsth_we_n",  {31'b0, we_n}, 32'd1);
    check("rsth_words", {24'b0, words_written}, 32'd0);
    check("rsth_busy",  {31'b0, busy}, 32'd0);
    check("rsth_ready", {31'b0, in_ready}, 32'd0);
    check("rsth_data",  write_data, 32'd0);
    repeat (3) @(negedge clk);

    check("sb_empty",    sb_q.size(), 32'd0);
    check("write_count", n_writes_seen, n_writes_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_pack_writer.md
Name: sram_pack_writer

Overview:
- Write-side producer for the 160x32 single-port SRAM wrapper.
- Accepts a stream of 9-bit samples over a valid/ready handshake and packs each pair into one 32-bit word: first sample in bits [8:0], second in [17:9], bits [31:18] zero.
- Drives the wrapper's we_n/w_addr/write_data write port at incrementing addresses.
- Its word layout is the exact inverse of the read side, which emits [8:0] first and then [17:9].

Parameters:
- DW, 9, sample width.
- WW, 32, SRAM word width.
- AW, 8, address width.
- DEPTH, 160, number of words writable per frame.
- BASE_ADDR, 0, first word address of a frame.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  arm a new frame; honoured only in IDLE or FULL.
- in_valid  in  1  sample valid.
- in_data  in  DW  sample value.
- in_ready  out  1  block accepts a sample this cycle.
- flush  in  1  end of frame; write any half-filled word and return to IDLE.
- mem_ry  in  1  SRAM ready; a write is issued only while high.
- we_n  out  1  SRAM write enable, active-low.
- w_addr  out  AW  SRAM write address.
- write_data  out  WW  packed word.
- words_written  out  AW  words written in the current frame.
- busy  out  1  high in any state except IDLE and FULL.
- full  out  1  DEPTH words written; frame closed.

Behaviour:
- Reset values: state=IDLE, we_n=1, w_addr=BASE_ADDR, write_data=0, in_ready=0, words_written=0, busy=0, full=0, flush_pend=0.
- Sample transfer: a sample is taken when in_valid && in_ready at a rising edge.
- in_ready is a decode of state only, so it never depends combinationally on in_valid.
- States: IDLE, LOW, HIGH, WRITE, FULL.
- IDLE:
  - start -> LOW.
  - On that edge: w_addr=BASE_ADDR, words_written=0, write_data=0.
- LOW:
  - in_ready=1.
  - Transfer: write_data[8:0]=in_data, [31:9]=0, go to HIGH.
  - flush without a transfer: go to IDLE; no write is issued.
  - flush with a transfer in the same cycle: accept the sample, set flush_pend, go to HIGH.
- HIGH:
  - in_ready=1.
  - Transfer: write_data[17:9]=in_data, go to WRITE.
  - flush without a transfer: [17:9]=0, set flush_pend, go to WRITE.
  - flush with a transfer: take the sample, set flush_pend, go to WRITE.
  - flush_pend set in LOW forces HIGH to wait for its transfer; flush asserted again is idempotent.
- WRITE:
  - in_ready=0; w_addr and write_data held stable.
  - we_n = ~mem_ry, decoded from state; low for exactly one cycle per word.
  - While mem_ry=0: hold in WRITE with we_n=1. There is no timeout.
  - On the edge with mem_ry=1:
    - words_written+1.
    - w_addr+1; on the DEPTH-th word, w_addr wraps back to BASE_ADDR.
    - Next state: FULL if words_written+1==DEPTH; else IDLE if flush_pend (clear it); else LOW.
- FULL:
  - full=1, in_ready=0; samples and flush are ignored.
  - start re-arms exactly as from IDLE and clears full.
- Latency: the second sample is accepted on edge N, and we_n is low during cycle N+1 if mem_ry=1. Peak throughput is 2 samples per 3 cycles.
- start while busy is ignored. rst asserted mid-frame aborts with no partial write; we_n is 1 the cycle after.
- words_written is AW bits, and DEPTH must be <= 2^AW - 1. words_written resets only on start or rst.

Decomposition:
- Shared package: state encodings, DW, WW, AW, DEPTH, and the pack field positions LO_LSB=0 and HI_LSB=9. The read-side unpacker uses the same package.
- No sub-module; the address/word counter stays inline.

Test Plan:
- Send 0x1A5 then 0x0F3 with mem_ry=1 -> one we_n pulse at w_addr=0, write_data=0x0001E7A5; then words_written=1, in_ready=1.
- Send 320 samples back to back -> 160 writes at addresses 0..159, full=1, in_ready=0. A 321st sample is not accepted; start re-arms with w_addr=0.
- Send 0x055 then flush in HIGH -> write_data=0x00000055 at the current address, then IDLE, busy=0.
- Hold mem_ry=0 for 5 cycles in WRITE -> we_n stays 1 and data is held; with mem_ry=1, one pulse; in_ready stays 0 throughout.
- flush together with the first sample in LOW -> sample taken, block waits in HIGH; the next sample is written, then IDLE.
- Assert rst in HIGH -> next cycle state=IDLE, we_n=1, words_written=0, and the pending half-word is dropped.
